// File: rtl/game_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_state_ctrl
//  Brief    : Dino game flow controller. Debounces the start/jump button,
//             turns the divided game clock into one-cycle score ticks, runs
//             the INIT/START/END/RESET state machine and keeps a 4-digit BCD
//             score plus the session high score.
//  Revision : 1.0  initial release
// ============================================================================
module game_state_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int RESET_HOLD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        game_clk_div,
    input  logic        collision,
    output logic [1:0]  game_state,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic        new_high
);

    // State encoding doubles as the game_state output value
    localparam logic [1:0] c_ST_INIT  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_END   = 2'd2;
    localparam logic [1:0] c_ST_RESET = 2'd3;

    localparam int              c_DB_W      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int              c_HOLD_W    = $clog2(RESET_HOLD_CYCLES) + 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [15:0]     c_SCORE_MAX = 16'h9999;

    // Button path registers
    logic              r_btn_meta;
    logic              r_btn_sync;
    logic              r_btn_db;
    logic              r_btn_db_d;
    logic [c_DB_W-1:0] r_db_cnt;

    // Tick path registers
    logic              r_gclk_meta;
    logic              r_gclk_sync;
    logic              r_gclk_sync_d;

    // FSM and score registers
    logic [1:0]          r_state;
    logic [15:0]         r_score;
    logic [15:0]         r_high;
    logic                r_new_high;
    logic [c_HOLD_W-1:0] r_hold_cnt;

    logic [1:0]          w_state_nxt;
    logic [15:0]         w_score_nxt;
    logic [15:0]         w_high_nxt;
    logic                w_new_high_nxt;
    logic [c_HOLD_W-1:0] w_hold_nxt;

    logic                w_start_pulse;
    logic                w_tick;
    logic [15:0]         w_score_inc;

    // BCD +1 with digit-wise ripple carry; holds at 9999
    function automatic logic [15:0] f_bcd_inc(input logic [15:0] v);
        logic [15:0] res;
        logic        carry;
        res   = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    res[i*4 +: 4] = 4'd0;
                end else begin
                    res[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        if (v == c_SCORE_MAX) begin
            res = v;
        end
        return res;
    endfunction

    // Synchronize the raw button and debounce it by counting mismatch cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_btn_db   <= 1'b0;
            r_btn_db_d <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_btn_meta <= btn_start;
            r_btn_sync <= r_btn_meta;
            r_btn_db_d <= r_btn_db;
            if (r_btn_sync != r_btn_db) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_btn_db <= r_btn_sync;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + c_DB_W'(1);
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // Synchronize the divided game clock and keep one delayed copy for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gclk_meta   <= 1'b0;
            r_gclk_sync   <= 1'b0;
            r_gclk_sync_d <= 1'b0;
        end else begin
            r_gclk_meta   <= game_clk_div;
            r_gclk_sync   <= r_gclk_meta;
            r_gclk_sync_d <= r_gclk_sync;
        end
    end

    assign w_start_pulse = r_btn_db & ~r_btn_db_d;
    assign w_tick        = r_gclk_sync & ~r_gclk_sync_d;
    assign w_score_inc   = f_bcd_inc(r_score);

    // Game state, score, high score and reset-hold counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_INIT;
            r_score    <= '0;
            r_high     <= '0;
            r_new_high <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_score    <= w_score_nxt;
            r_high     <= w_high_nxt;
            r_new_high <= w_new_high_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Next-state and datapath update; collision has priority over a tick
    always_comb begin
        w_state_nxt    = r_state;
        w_score_nxt    = r_score;
        w_high_nxt     = r_high;
        w_new_high_nxt = r_new_high;
        w_hold_nxt     = r_hold_cnt;
        case (r_state)
            c_ST_INIT: begin
                if (w_start_pulse) begin
                    w_state_nxt = c_ST_START;
                    w_score_nxt = '0;
                end
            end
            c_ST_START: begin
                if (collision) begin
                    w_state_nxt = c_ST_END;
                    // BCD digits order the same way as binary, so a plain compare works
                    if (r_score > r_high) begin
                        w_high_nxt     = r_score;
                        w_new_high_nxt = 1'b1;
                    end else begin
                        w_new_high_nxt = 1'b0;
                    end
                end else if (w_tick) begin
                    w_score_nxt = w_score_inc;
                end
            end
            c_ST_END: begin
                if (w_start_pulse) begin
                    w_state_nxt    = c_ST_RESET;
                    w_hold_nxt     = '0;
                    w_score_nxt    = '0;
                    w_new_high_nxt = 1'b0;
                end
            end
            c_ST_RESET: begin
                if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_nxt = c_ST_INIT;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt  = r_hold_cnt + c_HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_ST_INIT;
            end
        endcase
    end

    assign game_state = r_state;
    assign score      = r_score;
    assign high_score = r_high;
    assign new_high   = r_new_high;

endmodule
`default_nettype wire

// File: tb/tb_game_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_state_ctrl
//  Brief    : Self-checking bench for game_state_ctrl: directed vector table,
//             hand-written multi-cycle sequences and a randomized phase
//             compared against a transaction-level game model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_game_state_ctrl;

    logic        clk;
    logic        rst;
    logic        btn_start;
    logic        game_clk_div;
    logic        collision;
    logic [1:0]  game_state;
    logic [15:0] score;
    logic [15:0] high_score;
    logic        new_high;

    int total = 0;
    int bad   = 0;

    game_state_ctrl #(
        .DEBOUNCE_CYCLES   (4),
        .RESET_HOLD_CYCLES (16)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .btn_start    (btn_start),
        .game_clk_div (game_clk_div),
        .collision    (collision),
        .game_state   (game_state),
        .score        (score),
        .high_score   (high_score),
        .new_high     (new_high)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int OP_SHORT    = 0;  // 3-cycle glitch, must not debounce
    localparam int OP_PRESS    = 1;  // clean press and release
    localparam int OP_TICKS    = 2;  // n game clock rising edges
    localparam int OP_COLL     = 3;  // one-cycle collision
    localparam int OP_TICKCOLL = 4;  // collision in the same cycle as a tick
    localparam int OP_SETTLE   = 5;  // let RESET run out

    typedef struct {
        int          op;
        int          n;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [15:0] hi;
        logic        nh;
    } vec_t;

    vec_t tbl[19];

    // Transaction-level reference model: binary score, converted to BCD on compare
    int m_st;
    int m_sc;
    int m_hi;
    int m_nh;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic short_press();
        btn_start = 1'b1; cyc(3);
        btn_start = 1'b0; cyc(8);
    endtask

    task automatic press();
        btn_start = 1'b1; cyc(8);
        btn_start = 1'b0; cyc(8);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            game_clk_div = 1'b1; cyc(2);
            game_clk_div = 1'b0; cyc(2);
        end
        cyc(3);
    endtask

    task automatic coll();
        collision = 1'b1; cyc(1);
        collision = 1'b0; cyc(2);
    endtask

    // Rising edge of game_clk_div reaches the score on the third clk edge,
    // so collision is raised for exactly that cycle
    task automatic tick_coll();
        game_clk_div = 1'b1; cyc(2);
        collision    = 1'b1; cyc(1);
        collision    = 1'b0; game_clk_div = 1'b0; cyc(4);
    endtask

    task automatic chk_model(input string nm);
        chk({nm, ".state"}, 32'(game_state), 32'(m_st));
        chk({nm, ".score"}, 32'(score), 32'(to_bcd(m_sc)));
        chk({nm, ".high"}, 32'(high_score), 32'(to_bcd(m_hi)));
        chk({nm, ".new_high"}, 32'(new_high), 32'(m_nh));
    endtask

    initial begin
        int n3;
        int bad_in;
        int exited;
        int op;
        int n;

        tbl[0]  = '{OP_SHORT,    0,    2'd0, 16'h0000, 16'h0000, 1'b0};
        tbl[1]  = '{OP_PRESS,    0,    2'd1, 16'h0000, 16'h0000, 1'b0};
        tbl[2]  = '{OP_PRESS,    0,    2'd1, 16'h0000, 16'h0000, 1'b0};
        tbl[3]  = '{OP_TICKS,    12,   2'd1, 16'h0012, 16'h0000, 1'b0};
        tbl[4]  = '{OP_TICKS,    33,   2'd1, 16'h0045, 16'h0000, 1'b0};
        tbl[5]  = '{OP_TICKCOLL, 0,    2'd2, 16'h0045, 16'h0045, 1'b1};
        tbl[6]  = '{OP_TICKS,    3,    2'd2, 16'h0045, 16'h0045, 1'b1};
        tbl[7]  = '{OP_PRESS,    0,    2'd3, 16'h0000, 16'h0045, 1'b0};
        tbl[8]  = '{OP_SETTLE,   0,    2'd0, 16'h0000, 16'h0045, 1'b0};
        tbl[9]  = '{OP_PRESS,    0,    2'd1, 16'h0000, 16'h0045, 1'b0};
        tbl[10] = '{OP_TICKS,    30,   2'd1, 16'h0030, 16'h0045, 1'b0};
        tbl[11] = '{OP_COLL,     0,    2'd2, 16'h0030, 16'h0045, 1'b0};
        tbl[12] = '{OP_PRESS,    0,    2'd3, 16'h0000, 16'h0045, 1'b0};
        tbl[13] = '{OP_SETTLE,   0,    2'd0, 16'h0000, 16'h0045, 1'b0};
        tbl[14] = '{OP_PRESS,    0,    2'd1, 16'h0000, 16'h0045, 1'b0};
        tbl[15] = '{OP_TICKS,    99,   2'd1, 16'h0099, 16'h0045, 1'b0};
        tbl[16] = '{OP_TICKS,    1,    2'd1, 16'h0100, 16'h0045, 1'b0};
        tbl[17] = '{OP_TICKS,    9899, 2'd1, 16'h9999, 16'h0045, 1'b0};
        tbl[18] = '{OP_TICKS,    1,    2'd1, 16'h9999, 16'h0045, 1'b0};

        rst = 1'b1; btn_start = 1'b0; game_clk_div = 1'b0; collision = 1'b0;
        cyc(3);
        chk("rst.state", 32'(game_state), 32'd0);
        chk("rst.score", 32'(score), 32'd0);
        chk("rst.high", 32'(high_score), 32'd0);
        chk("rst.new_high", 32'(new_high), 32'd0);
        rst = 1'b0;
        cyc(2);

        // Directed vector table
        for (int i = 0; i < 19; i++) begin
            case (tbl[i].op)
                OP_SHORT:    short_press();
                OP_PRESS:    press();
                OP_TICKS:    ticks(tbl[i].n);
                OP_COLL:     coll();
                OP_TICKCOLL: tick_coll();
                default:     cyc(24);
            endcase
            chk($sformatf("vec%0d.state", i), 32'(game_state), 32'(tbl[i].st));
            chk($sformatf("vec%0d.score", i), 32'(score), 32'(tbl[i].sc));
            chk($sformatf("vec%0d.high", i), 32'(high_score), 32'(tbl[i].hi));
            chk($sformatf("vec%0d.new_high", i), 32'(new_high), 32'(tbl[i].nh));
        end

        // End the saturated game: new record
        coll();
        chk("end9999.state", 32'(game_state), 32'd2);
        chk("end9999.high", 32'(high_score), 32'h9999);
        chk("end9999.new_high", 32'(new_high), 32'd1);

        // RESET must last exactly 16 cycles with cleared score and flag
        btn_start = 1'b1;
        n3 = 0; bad_in = 0; exited = 0;
        for (int i = 0; i < 60 && exited == 0; i++) begin
            cyc(1);
            if (game_state == 2'd3) begin
                n3++;
                if (score != 16'h0000 || new_high != 1'b0) bad_in++;
            end else if (n3 > 0) begin
                exited = 1;
            end
        end
        chk("reset.len", 32'(n3), 32'd16);
        chk("reset.exited", 32'(exited), 32'd1);
        chk("reset.outputs", 32'(bad_in), 32'd0);
        chk("reset.next_state", 32'(game_state), 32'd0);
        // Button still held: no new start without a fresh press
        cyc(12);
        chk("held.state", 32'(game_state), 32'd0);
        btn_start = 1'b0;
        cyc(8);

        // Asynchronous reset in the middle of a game
        press();
        ticks(5);
        chk("pre_rst.score", 32'(score), 32'h0005);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst.state", 32'(game_state), 32'd0);
        chk("async_rst.score", 32'(score), 32'd0);
        chk("async_rst.high", 32'(high_score), 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(20);
        chk("post_rst.idle", 32'(game_state), 32'd0);

        // Randomized play against the game model
        m_st = 0; m_sc = 0; m_hi = 0; m_nh = 0;
        for (int k = 0; k < 80; k++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 2) begin
                press();
                if (m_st == 0) begin
                    m_st = 1; m_sc = 0;
                end else if (m_st == 2) begin
                    m_st = 3; m_sc = 0; m_nh = 0;
                end
                chk_model($sformatf("rnd%0d.press", k));
                if (m_st == 3) begin
                    cyc(24);
                    m_st = 0;
                    chk_model($sformatf("rnd%0d.settle", k));
                end
            end else if (op <= 6) begin
                n = int'($urandom_range(1, 15));
                ticks(n);
                if (m_st == 1) m_sc = (m_sc + n > 9999) ? 9999 : m_sc + n;
                chk_model($sformatf("rnd%0d.ticks", k));
            end else if (op <= 8) begin
                coll();
                if (m_st == 1) begin
                    m_st = 2;
                    if (m_sc > m_hi) begin
                        m_hi = m_sc; m_nh = 1;
                    end else begin
                        m_nh = 0;
                    end
                end
                chk_model($sformatf("rnd%0d.coll", k));
            end else begin
                short_press();
                chk_model($sformatf("rnd%0d.glitch", k));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
